pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter c_WIN_SCORE, default 5, meaning the points that end a game; legal range 1..15.
REQ-002 SHALL have parameter c_SERVE_FRAMES, default 60, meaning frame ticks held in SERVE before the ball moves; legal range 1..255.
REQ-003 SHALL have port i_Clk  input  1  meaning the single system clock (25 MHz pixel clock).
REQ-004 SHALL have port i_Rst_L  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port i_Frame_Tick  input  1  meaning a one-cycle pulse once per video frame.
REQ-006 SHALL have port i_RX_DV  input  1  meaning a one-cycle strobe: UART byte valid.
REQ-007 SHALL have port i_RX_Byte  input  8  meaning the UART command byte, sampled only when i_RX_DV=1.
REQ-008 SHALL have port i_P1_Miss  input  1  meaning a one-cycle pulse: ball passed the P1 edge, so P2 scores.
REQ-009 SHALL have port i_P2_Miss  input  1  meaning a one-cycle pulse: ball passed the P2 edge, so P1 scores.
REQ-010 SHALL have port o_Game_Active  output  1  meaning 1 only in PLAY (ball motion enabled).
REQ-011 SHALL have port o_Ball_Reset  output  1  meaning a one-cycle pulse that recentres the ball.
REQ-012 SHALL have port o_Serve_Dir  output  1  meaning the next serve direction: 0 toward P1, 1 toward P2.
REQ-013 SHALL have ports o_P1_Score and o_P2_Score  output  4 each  meaning the registered scores.
REQ-014 SHALL have port o_Winner  output  2  meaning 00 none, 01 P1, 10 P2.
REQ-015 SHALL have port o_State  output  3  meaning the current state encoding.

Function
REQ-016 SHALL implement states IDLE, SERVE, PLAY, PAUSE and GAMEOVER.
REQ-017 SHALL decode these commands: CMD_START 0x53 ('S'), CMD_PAUSE 0x50 ('P'), CMD_RESET 0x52 ('R'); all other bytes are ignored.
REQ-018 SHALL register every transition on the i_Clk edge that samples its cause (latency: 1 cycle).
REQ-019 SHALL, on CMD_START in IDLE or GAMEOVER, clear both scores, set o_Winner=00 and enter SERVE; CMD_START in any other state is ignored.
REQ-020 SHALL pulse o_Ball_Reset for exactly one cycle, the first cycle after every entry into SERVE.
REQ-021 SHALL count i_Frame_Tick pulses in SERVE and enter PLAY on the cycle after the c_SERVE_FRAMES-th tick.
REQ-022 SHALL reload the serve counter to 0 on every entry into SERVE.
REQ-023 SHALL, in PLAY on i_P1_Miss alone, increment o_P2_Score and set o_Serve_Dir=0.
REQ-024 SHALL, in PLAY on i_P2_Miss alone, increment o_P1_Score and set o_Serve_Dir=1.
REQ-025 SHALL, after a point, enter GAMEOVER with o_Winner set if the new score equals c_WIN_SCORE, otherwise enter SERVE.
REQ-026 SHALL, on simultaneous i_P1_Miss and i_P2_Miss in PLAY, award no point, keep o_Serve_Dir and re-enter SERVE.
REQ-027 SHALL ignore miss pulses in every state except PLAY.
REQ-028 SHALL never let a score exceed c_WIN_SCORE, because the increment is blocked outside PLAY.
REQ-029 SHALL, on CMD_RESET in any state, clear the scores, o_Winner and o_Serve_Dir and enter IDLE.
REQ-030 SHALL give CMD_RESET priority over a miss pulse arriving in the same cycle.
REQ-031 SHALL hold o_Game_Active=0 in every state except PLAY.

Reset
REQ-032 SHALL, while i_Rst_L=0, force state IDLE, both scores 0, o_Winner=00, o_Serve_Dir=0, o_Ball_Reset=0, o_Game_Active=0 and the serve counter to 0.
REQ-033 SHALL, after a reset released mid-game, stay in IDLE until CMD_START.

Configuration
REQ-034 SHALL, with PONG_CTRL_PAUSE_EN defined, treat CMD_PAUSE as PLAY->PAUSE and PAUSE->PLAY, and hold the scores and serve counter in PAUSE.
REQ-035 SHALL, with PONG_CTRL_PAUSE_EN defined, honour CMD_RESET in PAUSE.
REQ-036 SHALL, without PONG_CTRL_PAUSE_EN, ignore CMD_PAUSE and make PAUSE unreachable (its encoding stays reserved).

Structure
REQ-037 SHALL take the state encoding (IDLE=0, SERVE=1, PLAY=2, PAUSE=3, GAMEOVER=4), the command byte constants and the winner codes from shared package pong_ctrl_pkg.
REQ-038 SHALL place command decoding in one sub-module, pong_cmd_decode (i_RX_DV and i_RX_Byte in, one-cycle start/pause/reset strobes out); the FSM, counters and scores stay in pong_game_ctrl.

Verification
REQ-039 SHALL cover: reset, then 'S', then 60 frame ticks -> one o_Ball_Reset pulse after 'S', then o_Game_Active=1 on the cycle after tick 60.
REQ-040 SHALL cover: five i_P2_Miss pulses, each followed by a completed serve -> o_P1_Score=5, state GAMEOVER, o_Winner=01, further misses ignored.
REQ-041 SHALL cover: i_P1_Miss and i_P2_Miss in the same PLAY cycle -> scores unchanged, o_Serve_Dir unchanged, state SERVE.
REQ-042 SHALL cover, with PONG_CTRL_PAUSE_EN defined: 'P' in PLAY, then a miss, then 'P' -> no score change, state returns to PLAY; without the macro, 'P' leaves the state in PLAY.
REQ-043 SHALL cover: 'R' in the same cycle as i_P1_Miss while scores are 3:2 -> scores 0:0, state IDLE.
REQ-044 SHALL cover: i_Rst_L asserted mid-SERVE with score 2:1 -> immediate IDLE with 0:0, no o_Ball_Reset pulse.

Source files
------------

// File: rtl/pong_ctrl_pkg.sv
// Shared encodings for the pong game controller: FSM states, UART command bytes and winner codes.
package pong_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_PAUSE    = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_t;

  localparam logic [7:0] CMD_START = 8'h53;
  localparam logic [7:0] CMD_PAUSE = 8'h50;
  localparam logic [7:0] CMD_RESET = 8'h52;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/pong_ctrl_if.sv
// UART receive link carrying one command byte per valid strobe; the receiver drives, the decoder listens.
interface pong_ctrl_if;
  logic       rx_dv;
  logic [7:0] rx_byte;

  modport master (output rx_dv, output rx_byte);
  modport slave  (input  rx_dv, input  rx_byte);
endinterface

// File: rtl/pong_cmd_decode.sv
// Turns a UART byte into start/pause/reset strobes. Purely combinational so the
// FSM registers the resulting transition on the same edge that samples the byte.
module pong_cmd_decode
  import pong_ctrl_pkg::*;
(
  pong_ctrl_if.slave rx,
  output logic       start_stb,
  output logic       pause_stb,
  output logic       reset_stb
);

  always_comb begin
    start_stb = rx.rx_dv && (rx.rx_byte == CMD_START);
    pause_stb = rx.rx_dv && (rx.rx_byte == CMD_PAUSE);
    reset_stb = rx.rx_dv && (rx.rx_byte == CMD_RESET);
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game FSM: serve timing, scoring and winner detection driven by UART commands.
// Optional pause support is built when PONG_CTRL_PAUSE_EN is defined.
module pong_game_ctrl
  import pong_ctrl_pkg::*;
#(
  parameter int c_WIN_SCORE    = 5,
  parameter int c_SERVE_FRAMES = 60
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Frame_Tick,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_P1_Miss,
  input  logic       i_P2_Miss,
  output logic       o_Game_Active,
  output logic       o_Ball_Reset,
  output logic       o_Serve_Dir,
  output logic [3:0] o_P1_Score,
  output logic [3:0] o_P2_Score,
  output logic [1:0] o_Winner,
  output logic [2:0] o_State
);

  localparam logic [3:0] WIN_SCORE  = 4'(c_WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(c_SERVE_FRAMES - 1);

  state_t     state;
  logic [7:0] serve_cnt;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;
  logic       serve_dir;
  logic       ball_reset;
  logic       game_active;
  logic       start_stb;
  logic       pause_stb;
  logic       reset_stb;

  pong_ctrl_if rx_link ();

  assign rx_link.rx_dv   = i_RX_DV;
  assign rx_link.rx_byte = i_RX_Byte;

  pong_cmd_decode u_cmd_decode (
    .rx        (rx_link.slave),
    .start_stb (start_stb),
    .pause_stb (pause_stb),
    .reset_stb (reset_stb)
  );

`ifndef PONG_CTRL_PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause_stb;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= ST_IDLE;
      serve_cnt   <= 8'd0;
      p1_score    <= 4'd0;
      p2_score    <= 4'd0;
      winner      <= WIN_NONE;
      serve_dir   <= 1'b0;
      ball_reset  <= 1'b0;
      game_active <= 1'b0;
    end else begin
      ball_reset <= 1'b0;
      // A reset command outranks everything else arriving in the same cycle.
      if (reset_stb) begin
        state       <= ST_IDLE;
        serve_cnt   <= 8'd0;
        p1_score    <= 4'd0;
        p2_score    <= 4'd0;
        winner      <= WIN_NONE;
        serve_dir   <= 1'b0;
        game_active <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_GAMEOVER: begin
            if (start_stb) begin
              state      <= ST_SERVE;
              serve_cnt  <= 8'd0;
              p1_score   <= 4'd0;
              p2_score   <= 4'd0;
              winner     <= WIN_NONE;
              ball_reset <= 1'b1;
            end
          end
          ST_SERVE: begin
            if (i_Frame_Tick) begin
              if (serve_cnt == SERVE_LAST) begin
                state       <= ST_PLAY;
                game_active <= 1'b1;
              end else begin
                serve_cnt <= serve_cnt + 8'd1;
              end
            end
          end
          ST_PLAY: begin
            if (i_P1_Miss && i_P2_Miss) begin
              state       <= ST_SERVE;
              serve_cnt   <= 8'd0;
              ball_reset  <= 1'b1;
              game_active <= 1'b0;
            end else if (i_P1_Miss) begin
              p2_score    <= p2_score + 4'd1;
              serve_dir   <= 1'b0;
              game_active <= 1'b0;
              if ((p2_score + 4'd1) == WIN_SCORE) begin
                state  <= ST_GAMEOVER;
                winner <= WIN_P2;
              end else begin
                state      <= ST_SERVE;
                serve_cnt  <= 8'd0;
                ball_reset <= 1'b1;
              end
            end else if (i_P2_Miss) begin
              p1_score    <= p1_score + 4'd1;
              serve_dir   <= 1'b1;
              game_active <= 1'b0;
              if ((p1_score + 4'd1) == WIN_SCORE) begin
                state  <= ST_GAMEOVER;
                winner <= WIN_P1;
              end else begin
                state      <= ST_SERVE;
                serve_cnt  <= 8'd0;
                ball_reset <= 1'b1;
              end
            end
`ifdef PONG_CTRL_PAUSE_EN
            else if (pause_stb) begin
              state       <= ST_PAUSE;
              game_active <= 1'b0;
            end
`endif
          end
`ifdef PONG_CTRL_PAUSE_EN
          // Scores and the serve counter are simply left untouched while paused.
          ST_PAUSE: begin
            if (pause_stb) begin
              state       <= ST_PLAY;
              game_active <= 1'b1;
            end
          end
`endif
          default: begin
            state       <= ST_IDLE;
            game_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_State       = state;
  assign o_P1_Score    = p1_score;
  assign o_P2_Score    = p2_score;
  assign o_Winner      = winner;
  assign o_Serve_Dir   = serve_dir;
  assign o_Ball_Reset  = ball_reset;
  assign o_Game_Active = game_active;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with hand-computed expectations (default parameters).
module tb_pong_game_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       p1_miss;
  logic       p2_miss;
  logic       game_active;
  logic       ball_reset;
  logic       serve_dir;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;
  logic [2:0] state;

  int n_total = 0;
  int n_bad   = 0;

  pong_ctrl_if rx_bus ();

  pong_game_ctrl #(
    .c_WIN_SCORE    (5),
    .c_SERVE_FRAMES (60)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Frame_Tick  (frame_tick),
    .i_RX_DV       (rx_bus.rx_dv),
    .i_RX_Byte     (rx_bus.rx_byte),
    .i_P1_Miss     (p1_miss),
    .i_P2_Miss     (p2_miss),
    .o_Game_Active (game_active),
    .o_Ball_Reset  (ball_reset),
    .o_Serve_Dir   (serve_dir),
    .o_P1_Score    (p1_score),
    .o_P2_Score    (p2_score),
    .o_Winner      (winner),
    .o_State       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_bus.rx_dv   = 1'b1;
    rx_bus.rx_byte = b;
    step();
    rx_bus.rx_dv   = 1'b0;
    rx_bus.rx_byte = 8'h00;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic miss(input logic m1, input logic m2);
    p1_miss = m1;
    p2_miss = m2;
    step();
    p1_miss = 1'b0;
    p2_miss = 1'b0;
  endtask

  // Runs a full serve: 59 ticks keep SERVE, the 60th moves to PLAY.
  task automatic serve_ball(input string tag);
    frame();
    chk({tag, "_brst_once"}, 32'(ball_reset), 0);
    for (int i = 1; i < 59; i++) frame();
    chk({tag, "_hold_state"}, 32'(state), 1);
    chk({tag, "_hold_active"}, 32'(game_active), 0);
    frame();
    chk({tag, "_play_state"}, 32'(state), 2);
    chk({tag, "_play_active"}, 32'(game_active), 1);
  endtask

  initial begin
    rst_n          = 1'b0;
    frame_tick     = 1'b0;
    p1_miss        = 1'b0;
    p2_miss        = 1'b0;
    rx_bus.rx_dv   = 1'b0;
    rx_bus.rx_byte = 8'h00;
    step();
    step();

    chk("rst_state",  32'(state), 0);
    chk("rst_p1",     32'(p1_score), 0);
    chk("rst_p2",     32'(p2_score), 0);
    chk("rst_winner", 32'(winner), 0);
    chk("rst_dir",    32'(serve_dir), 0);
    chk("rst_brst",   32'(ball_reset), 0);
    chk("rst_active", 32'(game_active), 0);

    rst_n = 1'b1;
    step();
    frame();
    miss(1'b0, 1'b1);
    chk("idle_ignore_state", 32'(state), 0);
    chk("idle_ignore_p1", 32'(p1_score), 0);

    send_cmd(8'h41);
    chk("junk_byte_state", 32'(state), 0);
    send_cmd(8'h53);
    chk("start_state", 32'(state), 1);
    chk("start_brst", 32'(ball_reset), 1);
    serve_ball("serve1");

    send_cmd(8'h50);
`ifdef PONG_CTRL_PAUSE_EN
    chk("pause_state", 32'(state), 3);
    chk("pause_active", 32'(game_active), 0);
    miss(1'b0, 1'b1);
    chk("pause_miss_p1", 32'(p1_score), 0);
    chk("pause_miss_state", 32'(state), 3);
    send_cmd(8'h50);
    chk("resume_state", 32'(state), 2);
    chk("resume_active", 32'(game_active), 1);
`else
    chk("nopause_state", 32'(state), 2);
    chk("nopause_active", 32'(game_active), 1);
`endif

    send_cmd(8'h53);
    chk("start_in_play_state", 32'(state), 2);

    // Five P2 misses: P1 wins 5:0.
    for (int k = 1; k <= 4; k++) begin
      miss(1'b0, 1'b1);
      chk("p2miss_p1", 32'(p1_score), k);
      chk("p2miss_dir", 32'(serve_dir), 1);
      chk("p2miss_state", 32'(state), 1);
      chk("p2miss_brst", 32'(ball_reset), 1);
      serve_ball("rally");
    end
    miss(1'b0, 1'b1);
    chk("win_p1", 32'(p1_score), 5);
    chk("win_state", 32'(state), 4);
    chk("win_winner", 32'(winner), 1);
    chk("win_active", 32'(game_active), 0);
    chk("win_brst", 32'(ball_reset), 0);
    miss(1'b0, 1'b1);
    miss(1'b1, 1'b0);
    chk("over_p1_hold", 32'(p1_score), 5);
    chk("over_p2_hold", 32'(p2_score), 0);
    chk("over_state_hold", 32'(state), 4);

    // Restart from GAMEOVER, then a simultaneous miss.
    send_cmd(8'h53);
    chk("restart_state", 32'(state), 1);
    chk("restart_p1", 32'(p1_score), 0);
    chk("restart_winner", 32'(winner), 0);
    serve_ball("serve2");
    miss(1'b1, 1'b0);
    chk("p1miss_p2", 32'(p2_score), 1);
    chk("p1miss_dir", 32'(serve_dir), 0);
    serve_ball("serve3");
    miss(1'b1, 1'b1);
    chk("both_p1", 32'(p1_score), 0);
    chk("both_p2", 32'(p2_score), 1);
    chk("both_dir", 32'(serve_dir), 0);
    chk("both_state", 32'(state), 1);
    chk("both_brst", 32'(ball_reset), 1);

    // Build 3:2 then 'R' together with a P1 miss.
    serve_ball("serve4");
    miss(1'b0, 1'b1);
    serve_ball("serve5");
    miss(1'b0, 1'b1);
    serve_ball("serve6");
    miss(1'b0, 1'b1);
    serve_ball("serve7");
    miss(1'b1, 1'b0);
    chk("pre_r_p1", 32'(p1_score), 3);
    chk("pre_r_p2", 32'(p2_score), 2);
    serve_ball("serve8");
    rx_bus.rx_dv   = 1'b1;
    rx_bus.rx_byte = 8'h52;
    p1_miss        = 1'b1;
    step();
    rx_bus.rx_dv   = 1'b0;
    p1_miss        = 1'b0;
    chk("cmd_r_p1", 32'(p1_score), 0);
    chk("cmd_r_p2", 32'(p2_score), 0);
    chk("cmd_r_state", 32'(state), 0);
    chk("cmd_r_dir", 32'(serve_dir), 0);
    chk("cmd_r_active", 32'(game_active), 0);

    // Async reset in the middle of SERVE at 2:1.
    send_cmd(8'h53);
    serve_ball("serve9");
    miss(1'b0, 1'b1);
    serve_ball("serve10");
    miss(1'b0, 1'b1);
    serve_ball("serve11");
    miss(1'b1, 1'b0);
    chk("pre_rst_p1", 32'(p1_score), 2);
    chk("pre_rst_p2", 32'(p2_score), 1);
    for (int i = 0; i < 10; i++) frame();
    rst_n = 1'b0;
    #2;
    chk("async_state", 32'(state), 0);
    chk("async_p1", 32'(p1_score), 0);
    chk("async_p2", 32'(p2_score), 0);
    chk("async_brst", 32'(ball_reset), 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) frame();
    chk("post_rst_state", 32'(state), 0);
    chk("post_rst_brst", 32'(ball_reset), 0);
    chk("post_rst_active", 32'(game_active), 0);
    send_cmd(8'h53);
    chk("post_rst_start", 32'(state), 1);
    serve_ball("serve12");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
